// File: rtl/pulse_period_meter.sv
// Measures the spacing of tick_in strobes and flags loss of the stream; optional lock detect under PULSE_PERIOD_METER_LOCK_EN.
// Latency: period reported one cycle after the closing tick; timeout asserts one cycle after the overrun cycle.
// Backpressure: none, every tick is consumed on the cycle it is sampled.
module pulse_period_meter (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic [31:0] timeout_cnt,
    output logic [31:0] period_out,
    output logic        period_valid,
    output logic        timeout,
    output logic        locked
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] cnt_q;

`ifdef PULSE_PERIOD_METER_LOCK_EN
    // Set once a period has been reported in the current MEASURE stay, so the
    // reset value of period_out is never mistaken for a previous period.
    logic        have_prev_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 32'd0;
            period_out   <= 32'd0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
`ifdef PULSE_PERIOD_METER_LOCK_EN
            locked       <= 1'b0;
            have_prev_q  <= 1'b0;
`endif
        end else begin
            period_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick_in) begin
                        cnt_q   <= 32'd0;
                        state_q <= MEASURE;
`ifdef PULSE_PERIOD_METER_LOCK_EN
                        have_prev_q <= 1'b0;
`endif
                    end
                end
                MEASURE: begin
                    if (tick_in) begin
                        period_out   <= cnt_q;
                        period_valid <= 1'b1;
                        cnt_q        <= 32'd0;
`ifdef PULSE_PERIOD_METER_LOCK_EN
                        locked       <= have_prev_q && (cnt_q == period_out);
                        have_prev_q  <= 1'b1;
`endif
                    end else if (cnt_q >= timeout_cnt) begin
                        // >= rather than == so a limit lowered below the running
                        // count still trips on the next cycle instead of wrapping.
                        state_q <= TIMEOUT;
                        timeout <= 1'b1;
                        cnt_q   <= 32'd0;
`ifdef PULSE_PERIOD_METER_LOCK_EN
                        locked  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                TIMEOUT: begin
                    if (tick_in) begin
                        cnt_q   <= 32'd0;
                        timeout <= 1'b0;
                        state_q <= MEASURE;
`ifdef PULSE_PERIOD_METER_LOCK_EN
                        have_prev_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef PULSE_PERIOD_METER_LOCK_EN
    assign locked = 1'b0;
`endif

endmodule
